// File: rtl/relprime_processor.sv
// Computes RelPrime(n): the smallest m >= 2 with gcd(n, m) == 1.
// Multicycle search over m; each GCD runs as a subtractive Euclid loop, one subtraction per clock.
module relprime_processor #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_result
);

    localparam logic [WIDTH-1:0] M_START = WIDTH'(2);
    localparam logic [WIDTH-1:0] M_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_LOAD  = 3'd1,
        S_GCD   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_IDLE  = 3'd5
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_last_n;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_out;

    assign out_result = r_out;

    // Search FSM; r_result holds the pending answer until DONE publishes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_INIT;
            r_n      <= ZERO;
            r_m      <= ZERO;
            r_a      <= ZERO;
            r_b      <= ZERO;
            r_last_n <= ZERO;
            r_result <= ZERO;
            r_out    <= ZERO;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_n <= in_data;
                    r_m <= M_START;
                    if (in_data == ZERO) begin
                        r_result <= ZERO;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_a     <= r_n;
                    r_b     <= r_m;
                    r_state <= S_GCD;
                end
                S_GCD: begin
                    if (r_a == r_b) begin
                        r_state <= S_CHECK;
                    end else if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                S_CHECK: begin
                    if (r_a == ONE) begin
                        r_result <= r_m;
                        r_state  <= S_DONE;
                    end else if (r_m == M_MAX) begin
                        // Candidate space exhausted: report 0 rather than wrap.
                        r_result <= ZERO;
                        r_state  <= S_DONE;
                    end else begin
                        r_m     <= r_m + ONE;
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_out    <= r_result;
                    r_last_n <= r_n;
                    r_state  <= S_IDLE;
                end
                S_IDLE: begin
                    if (in_data != r_last_n) begin
                        r_state <= S_INIT;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relprime_processor.sv
// Randomized self-checking bench for relprime_processor against a gcd-based reference model,
// including exact completion-cycle prediction.
module tb_relprime_processor;

    logic        CLK;
    logic        RST;
    logic [15:0] in_data;
    logic [15:0] out_result;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] model_out = 16'd0;

    relprime_processor #(.WIDTH(16)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_data   (in_data),
        .out_result(out_result)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int unsigned gcd_f(input int unsigned x, input int unsigned y);
        int unsigned p = x;
        int unsigned q = y;
        int unsigned r;
        while (q != 0) begin
            r = p % q;
            p = q;
            q = r;
        end
        return p;
    endfunction

    function automatic logic [15:0] relprime_f(input logic [15:0] n);
        if (n == 16'd0) return 16'd0;
        for (int unsigned m = 2; m <= 65535; m++) begin
            if (gcd_f(32'(n), m) == 1) return 16'(m);
        end
        return 16'd0;
    endfunction

    // Subtractions taken by subtractive Euclid: sum of division quotients minus one.
    function automatic int unsigned sub_steps(input int unsigned x, input int unsigned y);
        int unsigned p = (x > y) ? x : y;
        int unsigned q = (x > y) ? y : x;
        int unsigned r;
        int unsigned s = 0;
        while (q != 0) begin
            s += p / q;
            r = p % q;
            p = q;
            q = r;
        end
        return s - 1;
    endfunction

    // Clock edges from the INIT edge through the DONE edge, inclusive.
    function automatic int unsigned lat_core(input logic [15:0] n);
        int unsigned total = 2;
        int unsigned rp;
        if (n == 16'd0) return 2;
        rp = 32'(relprime_f(n));
        for (int unsigned m = 2; m <= rp; m++) begin
            total += 3 + sub_steps(32'(n), m);
        end
        return total;
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply n and check out_result cycle by cycle: unchanged until the predicted edge, then the answer.
    task automatic run(input logic [15:0] n, input int unsigned from_idle,
                       input int unsigned sw_at, input logic [15:0] sw_val);
        logic [15:0] exp_v = relprime_f(n);
        int unsigned lat   = lat_core(n) + from_idle;
        int unsigned bad   = 0;
        in_data = n;
        for (int unsigned c = 1; c <= lat; c++) begin
            @(posedge CLK);
            #1;
            if (c == sw_at) in_data = sw_val;
            if (c < lat) begin
                if (out_result != model_out) bad++;
            end else begin
                chk($sformatf("result n=%0d", n), 32'(out_result), 32'(exp_v));
            end
        end
        chk($sformatf("hold_before_done n=%0d", n), bad, 0);
        model_out = exp_v;
    endtask

    task automatic hold_cycles(input int unsigned cycles, input string name);
        int unsigned bad = 0;
        for (int unsigned c = 0; c < cycles; c++) begin
            @(posedge CLK);
            #1;
            if (out_result != model_out) bad++;
        end
        chk(name, bad, 0);
    endtask

    initial begin
        logic [15:0] rn;

        // Pin the model with hand-derived values.
        chk("model 5040", 32'(relprime_f(16'd5040)), 11);
        chk("model 2310", 32'(relprime_f(16'd2310)), 13);
        chk("model FFFF", 32'(relprime_f(16'hFFFF)), 2);
        chk("model 2", 32'(relprime_f(16'd2)), 3);
        chk("lat n=1", lat_core(16'd1), 6);
        chk("lat n=3", lat_core(16'd3), 7);
        chk("lat n=0", lat_core(16'd0), 2);

        RST = 1'b1;
        in_data = 16'd5040;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset out", 32'(out_result), 0);
        RST = 1'b0;

        run(16'd5040, 0, 0, 16'd0);
        // Operand change mid-run is ignored until the FSM is back in IDLE.
        run(16'd2310, 1, 5, 16'd1);
        run(16'd1, 1, 0, 16'd0);
        run(16'd3, 1, 0, 16'd0);
        run(16'd2, 1, 0, 16'd0);
        run(16'hFFFF, 1, 0, 16'd0);
        run(16'd0, 1, 0, 16'd0);
        hold_cycles(1000, "hold idle n=0");
        run(16'd2, 1, 0, 16'd0);
        hold_cycles(1000, "hold idle n=2");

        for (int i = 0; i < 6; i++) begin
            do rn = 16'($urandom_range(1, 1023)); while (rn == in_data);
            run(rn, 1, 0, 16'd0);
        end

        // Reset in the middle of a 5040 computation.
        in_data = 16'd5040;
        hold_cycles(200, "hold mid 5040");
        RST = 1'b1;
        #1;
        chk("async reset out", 32'(out_result), 0);
        model_out = 16'd0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run(16'd5040, 0, 0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
